// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the FSM state encoding and the byte-offset width used for word indexing.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Byte addresses are word aligned when these low bits are zero.
  localparam int BYTE_OFF_W = 2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin choice: a lone request always wins; on a tie the port
// that was not served last wins.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant
);

  // NOTE: assign a default first in always_comb so no path leaves grant unassigned (no latch).
  always_comb begin
    grant = PORT0;
    if (req0 && req1) grant = ~last;
    else if (req1)    grant = PORT1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE samples and latches the winner, ACCESS
// drives the memory for one cycle, DONE returns a one-cycle ack (and err) pulse.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic              memwrite,
  output logic              memread,
  output logic [ADDR_W-1:0] inadd,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] outdata
);

  state_t state, next_state;

  logic              grant;
  logic              gport;
  logic              last;
  logic              lwe;
  logic              legal;
  logic              any_req;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_legal;

  dmem_rr_pick u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last),
    .grant (grant)
  );

  assign any_req   = req0 | req1;
  assign sel_we    = (grant == PORT1) ? we1    : we0;
  assign sel_addr  = (grant == PORT1) ? addr1  : addr0;
  assign sel_wdata = (grant == PORT1) ? wdata1 : wdata0;

  // Legality is decided once at grant time so ACCESS/DONE only read a flag.
  assign sel_legal = (sel_addr[BYTE_OFF_W-1:0] == '0) &&
                     ((sel_addr >> BYTE_OFF_W) < ADDR_W'(MEM_WORDS));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ACCESS;
      ACCESS:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // inadd/wdata double as the latched request fields and hold between accesses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gport  <= PORT0;
      last   <= PORT1;
      lwe    <= 1'b0;
      legal  <= 1'b0;
      inadd  <= '0;
      wdata  <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        gport <= grant;
        last  <= grant;
        lwe   <= sel_we;
        legal <= sel_legal;
        inadd <= sel_addr;
        wdata <= sel_wdata;
      end
      if (state == ACCESS && legal && !lwe) begin
        if (gport == PORT1) rdata1 <= outdata;
        else                rdata0 <= outdata;
      end
    end
  end

  // Strobes decode straight from state so an async reset removes them at once.
  assign memwrite = (state == ACCESS) && legal &&  lwe;
  assign memread  = (state == ACCESS) && legal && !lwe;

  assign ack0 = (state == DONE) && (gport == PORT0);
  assign ack1 = (state == DONE) && (gport == PORT1);
  assign err0 = ack0 && !legal;
  assign err1 = ack1 && !legal;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 32-word data memory
// preloaded with 250,200,20,10,300,450.
module tb_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic        memwrite, memread;
  logic [31:0] inadd, wdata, outdata;

  logic [31:0] mem [32];
  int n_total;
  int n_pass;
  logic [31:0] exp_r0, exp_r1;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .ack0     (ack0),
    .err0     (err0),
    .rdata0   (rdata0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .ack1     (ack1),
    .err1     (err1),
    .rdata1   (rdata1),
    .memwrite (memwrite),
    .memread  (memread),
    .inadd    (inadd),
    .wdata    (wdata),
    .outdata  (outdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    mem[0] = 32'd250; mem[1] = 32'd200; mem[2] = 32'd20;
    mem[3] = 32'd10;  mem[4] = 32'd300; mem[5] = 32'd450;
  end

  always_comb begin
    outdata = 32'd0;
    if (inadd < 32'd128) outdata = mem[inadd[6:2]];
  end

  always @(posedge clock) begin
    if (memwrite && inadd < 32'd128) mem[inadd[6:2]] <= wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One request on one port; starts and ends at a negedge with the DUT in IDLE.
  task automatic xfer(input int p, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic exp_err,
                      input logic [31:0] exp_rd, input string tag);
    @(negedge clock);
    if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    else        begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    @(negedge clock);
    req0 = 1'b0; req1 = 1'b0;
    addr0 = 32'hFFFF_FFFF; addr1 = 32'hFFFF_FFFF; wdata0 = '0; wdata1 = '0;
    check({tag, "_mw"}, memwrite, we && !exp_err);
    check({tag, "_mr"}, memread, !we && !exp_err);
    check({tag, "_noack"}, {ack0, ack1}, 2'b00);
    @(negedge clock);
    check({tag, "_ack"}, {ack0, ack1}, (p == 0) ? 2'b10 : 2'b01);
    check({tag, "_err"}, {err0, err1}, (p == 0) ? {exp_err, 1'b0} : {1'b0, exp_err});
    check({tag, "_rdata"}, (p == 0) ? rdata0 : rdata1, exp_rd);
    @(negedge clock);
    check({tag, "_idle"}, {ack0, ack1, memread, memwrite}, 4'b0000);
  endtask

  initial begin
    n_total = 0; n_pass = 0;
    reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    repeat (2) @(negedge clock);
    check("rst_ack_err", {ack0, ack1, err0, err1}, 4'b0000);
    check("rst_strobes", {memwrite, memread}, 2'b00);
    check("rst_inadd", inadd, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    reset = 1'b0;

    // Simultaneous reads: after reset port 0 wins first, then grants alternate.
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
    for (int g = 0; g < 4; g++) begin
      @(negedge clock);
      check($sformatf("rr%0d_inadd", g), inadd, (g % 2 == 0) ? 32'd0 : 32'd4);
      check($sformatf("rr%0d_mr", g), memread, 1'b1);
      @(negedge clock);
      check($sformatf("rr%0d_ack", g), {ack0, ack1}, (g % 2 == 0) ? 2'b10 : 2'b01);
      check($sformatf("rr%0d_err", g), {err0, err1}, 2'b00);
      @(negedge clock);
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_rdata0", rdata0, 32'd250);
    check("rr_rdata1", rdata1, 32'd200);
    exp_r0 = 32'd250; exp_r1 = 32'd200;

    // Plain read, write then read-back across ports.
    exp_r0 = 32'd20;
    xfer(0, 1'b0, 32'd8, 32'd0, 1'b0, exp_r0, "rd8");
    xfer(1, 1'b1, 32'd24, 32'd77, 1'b0, exp_r1, "wr24");
    exp_r0 = 32'd77;
    xfer(0, 1'b0, 32'd24, 32'd0, 1'b0, exp_r0, "rd24");

    // Illegal accesses: misaligned and out of range.
    xfer(0, 1'b1, 32'd6, 32'd99, 1'b1, exp_r0, "wr6_bad");
    xfer(0, 1'b1, 32'd128, 32'd99, 1'b1, exp_r0, "wr128_bad");
    xfer(0, 1'b0, 32'd127, 32'd0, 1'b1, exp_r0, "rd127_bad");
    exp_r0 = 32'd200;
    xfer(0, 1'b0, 32'd4, 32'd0, 1'b0, exp_r0, "rd4_after_bad");
    exp_r0 = 32'd20;
    xfer(0, 1'b0, 32'd8, 32'd0, 1'b0, exp_r0, "rd8_after_bad");

    // Reset in the middle of a write access.
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd12; wdata0 = 32'd5;
    @(negedge clock);
    req0 = 1'b0;
    check("mid_mw_before", memwrite, 1'b1);
    check("mid_inadd", inadd, 32'd12);
    reset = 1'b1;
    #1;
    check("mid_mw_dropped", {memwrite, memread}, 2'b00);
    @(negedge clock);
    check("mid_noack", {ack0, ack1, err0, err1}, 4'b0000);
    check("mid_rdata0_rst", rdata0, 32'd0);
    reset = 1'b0;
    exp_r0 = 32'd10;
    xfer(0, 1'b0, 32'd12, 32'd0, 1'b0, exp_r0, "rd12_after_rst");

    // A lone port-1 request wins right after reset pointer state.
    exp_r1 = 32'd450;
    xfer(1, 1'b0, 32'd20, 32'd0, 1'b0, exp_r1, "rd20_p1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, requester/memory address width in bits.
REQ-002 Parameter DATA_W, default 32, data width in bits.
REQ-003 Parameter MEM_WORDS, default 32, number of words in the data memory.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 reqN  input  1  (N=0,1) access request from requester N.
REQ-007 weN  input  1  1=write, 0=read; sampled with reqN.
REQ-008 addrN  input  ADDR_W  byte address from requester N.
REQ-009 wdataN  input  DATA_W  write data from requester N.
REQ-010 ackN  output  1  one-cycle completion pulse to requester N.
REQ-011 errN  output  1  valid with ackN; 1 = access rejected.
REQ-012 rdataN  output  DATA_W  read data; valid with ackN, held until next ackN.
REQ-013 memwrite  output  1  write strobe to data memory.
REQ-014 memread  output  1  read strobe to data memory.
REQ-015 inadd  output  ADDR_W  byte address to data memory.
REQ-016 wdata  output  DATA_W  write data to data memory.
REQ-017 outdata  input  DATA_W  combinational read data from data memory.

Function
REQ-018 FSM states IDLE, ACCESS, DONE; IDLE is the reset state.
REQ-019 IDLE: if any reqN=1, latch winner's we/addr/wdata and go to ACCESS next edge; else stay.
REQ-020 Both reqs in the same IDLE cycle: grant the port not served last (round-robin); after reset port 0 wins first.
REQ-021 One req only: grant it regardless of round-robin pointer; pointer updates to the granted port.
REQ-022 ACCESS lasts exactly one cycle; inadd/wdata driven from latched fields; memwrite=we, memread=!we, both only in ACCESS and only if access is legal.
REQ-023 Read: outdata captured into the granted port's rdata register at the end of ACCESS.
REQ-024 DONE lasts one cycle: ackN=1 for granted port only, then IDLE.
REQ-025 Latency: req sampled in IDLE at cycle T -> ACCESS at T+1 -> ackN at T+2; max throughput one access per 3 cycles.
REQ-026 Requester fields need be stable only in the sampling IDLE cycle; req still high in IDLE after ack is a new request.
REQ-027 Illegal access: addr[1:0]!=0 or addr>>2 >= MEM_WORDS; no memwrite/memread asserted, errN=1 with ackN, rdataN unchanged.
REQ-028 Outside ACCESS, memwrite=memread=0 and inadd/wdata hold last driven values.
REQ-029 ackN and errN never asserted for both ports in the same cycle.

Reset
REQ-030 Reset forces IDLE, ack0/ack1/err0/err1/memwrite/memread=0, inadd/wdata/rdata0/rdata1=0, round-robin pointer=port 1 (so port 0 wins next).
REQ-031 Reset during ACCESS deasserts memwrite immediately (combinationally from state); the pending access is dropped with no ack.
REQ-032 First request after reset release is sampled no earlier than the first rising edge with reset=0.

Structure
REQ-033 Shared package dmem_arb_pkg holds the FSM state type and word-index/alignment helper constants.
REQ-034 Round-robin choice lives in one sub-module dmem_rr_pick (two requests + last-served in, grant index out).
REQ-035 Memory-side ports connect by name to the data memory's memwrite/memread/inadd/wdata/outdata.

Verification (data memory reset contents mem[0..5]=250,200,20,10,300,450)
REQ-036 req0 read addr0=8 -> ack0 two cycles after sampling, rdata0=20, err0=0, memread high exactly one cycle.
REQ-037 req1 write addr1=24 wdata1=77, then req0 read addr0=24 -> ack1 err1=0, then rdata0=77.
REQ-038 req0 and req1 both read (addr 0 and 4) repeatedly -> grants alternate 0,1,0,1; rdata0=250, rdata1=200.
REQ-039 req0 write addr0=6 and separately addr0=128 -> err0=1 each, memwrite never asserted, memory unchanged.
REQ-040 reset asserted mid-ACCESS of write addr=12 wdata=5 -> memwrite drops same cycle, no ack, mem[3] reads 10 afterward.
